// File: rtl/debouncer_pkg.sv
// Purpose: shared types and helpers for the debouncer bank and its channels.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents:
//   db_state_t     per-channel conditioner state (LOW, RISING, HIGH, FALLING)
//   stable_cycles  number of clock cycles a new level must persist
//   state_level    logical level presented for a given state
package debouncer_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } db_state_t;

  // freq_mhz in MHz, delay_ms in ms -> cycles
  function automatic int unsigned stable_cycles(input int unsigned freq_mhz,
                                                input int unsigned delay_ms);
    return freq_mhz * delay_ms * 1000;
  endfunction

  // The accepted level only changes when a count completes, so the counting
  // states keep presenting the level they started from.
  function automatic logic state_level(input db_state_t st);
    return (st == HIGH) || (st == FALLING);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Purpose: one conditioner channel: 2-flop synchroniser, symmetric debounce FSM, edge pulses.
// Latency: pin stable from posedge k -> level/pulse change visible after posedge k+2+STABLE_CYCLES.
// Backpressure: none; free-running, outputs are level/pulse only.
//
// Ports:
//   clk        system clock
//   rstN       synchronous active-low reset
//   pin        raw asynchronous pin
//   level      debounced logical level (registered)
//   rise_pulse one-cycle pulse when level goes 0->1 (registered)
//   fall_pulse one-cycle pulse when level goes 1->0 (registered)
//   event_nxt  combinational: a pulse will be presented after the next edge
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter bit          INVERT_BIT    = 1'b0,
  parameter bit          INIT_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rstN,
  input  logic pin,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_nxt
);

  localparam int unsigned      CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             SYNC_INIT  = INIT_BIT ^ INVERT_BIT;
  localparam db_state_t        STATE_INIT = INIT_BIT ? HIGH : LOW;
  // With a one-cycle stable time the first disagreeing sample is already
  // the whole required window, so the counting state is skipped.
  localparam bit               SINGLE     = (STABLE_CYCLES == 1);

  // ---------------------------------------------------------------------
  // Synchroniser; reset value matches the pin level implied by INIT_BIT so
  // that leaving reset does not look like a pin change.
  // ---------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic sample;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1 <= SYNC_INIT;
      sync2 <= SYNC_INIT;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ INVERT_BIT;

  // ---------------------------------------------------------------------
  // Debounce FSM and stability counter
  // ---------------------------------------------------------------------
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= STATE_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOW: begin
        if (sample) begin
          if (SINGLE) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RISING;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      RISING: begin
        if (!sample) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sample) begin
          if (SINGLE) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            state_nxt = FALLING;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      FALLING: begin
        if (sample) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register: the level follows the state one cycle later and the
  // pulses are derived from the same comparison, so pulse and level edge
  // always land in the same cycle and a pulse is exactly one cycle wide.
  // ---------------------------------------------------------------------
  logic lvl_fsm;
  assign lvl_fsm   = state_level(state);
  assign event_nxt = lvl_fsm ^ level;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      level      <= INIT_BIT;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      level      <= lvl_fsm;
      rise_pulse <= lvl_fsm & ~level;
      fall_pulse <= ~lvl_fsm & level;
    end
  end

endmodule

// File: rtl/debouncer_bank.sv
// Purpose: bank of independent debounce channels with per-channel polarity and reset level.
// Latency: pin stable from posedge k -> value_out/pulses/any_event change after posedge k+2+STABLE_CYCLES.
// Backpressure: none; events are single-cycle pulses and are never held or queued.
//
// Ports:
//   clk         system clock
//   rstN        synchronous active-low reset
//   value_in    raw asynchronous pin levels, CHANNELS bits
//   value_out   debounced logical levels (after INVERT)
//   rise_pulse  per-channel 1-cycle pulse on 0->1
//   fall_pulse  per-channel 1-cycle pulse on 1->0
//   any_event   registered OR of all pulses, aligned with them
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int unsigned         CHANNELS   = 4,
  parameter int unsigned         CLK_FREQ   = 50,
  parameter int unsigned         TIME_DELAY = 20,
  parameter logic [CHANNELS-1:0] INVERT     = '0,
  parameter logic [CHANNELS-1:0] INIT_LEVEL = '0
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CHANNELS-1:0] value_in,
  output logic [CHANNELS-1:0] value_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_event
);

  localparam int unsigned STABLE_CYCLES = stable_cycles(CLK_FREQ, TIME_DELAY);

  logic [CHANNELS-1:0] event_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INVERT_BIT    (INVERT[i]),
      .INIT_BIT      (INIT_LEVEL[i])
    ) u_ch (
      .clk        (clk),
      .rstN       (rstN),
      .pin        (value_in[i]),
      .level      (value_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .event_nxt  (event_nxt[i])
    );
  end

  // Registered from the channels' next-pulse terms so it rises and falls in
  // the same cycle as the pulses themselves.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |event_nxt;
    end
  end

endmodule

// File: tb/tb_debouncer_bank.sv
module tb_debouncer_bank;
  import debouncer_pkg::*;

  localparam int          CH        = 4;
  localparam int unsigned STABLE    = stable_cycles(1, 1);
  localparam logic [3:0]  INV       = 4'b0100;
  localparam logic [3:0]  INIT      = 4'b0010;
  localparam logic [3:0]  IDLE_PINS = INIT ^ INV;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] value_in;
  logic [3:0] value_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       any_event;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debouncer_bank #(
    .CHANNELS   (CH),
    .CLK_FREQ   (1),
    .TIME_DELAY (1),
    .INVERT     (INV),
    .INIT_LEVEL (INIT)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .value_in   (value_in),
    .value_out  (value_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_event  (any_event)
  );

  // Reference: a channel's level flips once its logical sample (pin two
  // edges ago) has disagreed with the level for STABLE consecutive edges;
  // the flip is presented one edge later, with a pulse in that cycle.
  logic [3:0] m_lvl, m_out, m_prev, m_rise, m_fall, h1, h2;
  int         run [CH];
  bit         model_live = 1'b0;

  always @(posedge clk) begin
    if (!rstN) begin
      m_lvl  = INIT;
      m_out  = INIT;
      m_rise = '0;
      m_fall = '0;
      h1     = INIT;
      h2     = INIT;
      for (int i = 0; i < CH; i++) run[i] = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_prev = m_out;
      m_out  = m_lvl;
      m_rise = m_out & ~m_prev;
      m_fall = m_prev & ~m_out;
      for (int i = 0; i < CH; i++) begin
        if (h2[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == int'(STABLE)) begin
            m_lvl[i] = ~m_lvl[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      h2 = h1;
      h1 = value_in ^ INV;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if ({value_out, rise_pulse, fall_pulse, any_event} !==
          {m_out, m_rise, m_fall, |(m_rise | m_fall)}) begin
        errors++;
        $display("FAIL model t=%0t: got out=%b rise=%b fall=%b any=%b, expected out=%b rise=%b fall=%b any=%b",
                 $time, value_out, rise_pulse, fall_pulse, any_event,
                 m_out, m_rise, m_fall, |(m_rise | m_fall));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Pulse activity observed inside a window
  logic [3:0] rise_or, fall_or;
  int         rise_tot, fall_tot, any_tot;

  task automatic clear_seen();
    rise_or  = '0;
    fall_or  = '0;
    rise_tot = 0;
    fall_tot = 0;
    any_tot  = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rise_or  |= rise_pulse;
      fall_or  |= fall_pulse;
      rise_tot += $countones(rise_pulse);
      fall_tot += $countones(fall_pulse);
      any_tot  += int'(any_event);
    end
  endtask

  // Called just after driving at a negedge: lat counts posedges from the
  // first one that samples the new inputs (edge 0).
  task automatic wait_event(output int lat, output logic [3:0] o_out,
                            output logic [3:0] o_rise, output logic [3:0] o_fall);
    lat    = -1;
    o_out  = 'x;
    o_rise = 'x;
    o_fall = 'x;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk);
      #1;
      if (any_event === 1'b1) begin
        lat    = c;
        o_out  = value_out;
        o_rise = rise_pulse;
        o_fall = fall_pulse;
        break;
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] pins;
    int         hold;
    logic [3:0] exp_out;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int         lat;
  logic [3:0] s_out, s_rise, s_fall;
  logic [3:0] rnd_pins;
  int         rnd_hold;

  initial begin
    vecs[0] = '{"idle after reset",   4'b0110, 2000, 4'b0010, 4'b0000, 4'b0000};
    vecs[1] = '{"ch1 fall",           4'b0100, 1010, 4'b0000, 4'b0000, 4'b0010};
    vecs[2] = '{"ch1 glitch 999",     4'b0110,  999, 4'b0000, 4'b0000, 4'b0000};
    vecs[3] = '{"ch1 after glitch",   4'b0100, 1010, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{"ch1 high 1000",      4'b0110, 1000, 4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{"ch1 1000 accepted",  4'b0100, 1010, 4'b0000, 4'b0010, 4'b0010};
    vecs[6] = '{"ch1 restore",        4'b0110, 1010, 4'b0010, 4'b0010, 4'b0000};
    vecs[7] = '{"ch2 inverted rise",  4'b0010, 1010, 4'b0110, 4'b0100, 4'b0000};
    vecs[8] = '{"ch2 inverted fall",  4'b0110, 1010, 4'b0010, 4'b0000, 4'b0100};

    rstN     = 1'b0;
    value_in = IDLE_PINS;
    repeat (3) @(negedge clk);
    check("reset value_out", 32'(value_out), 32'(INIT));
    check("reset pulses", 32'({rise_pulse, fall_pulse, any_event}), 32'd0);
    rstN = 1'b1;

    // Directed table
    for (int v = 0; v < NV; v++) begin
      value_in = vecs[v].pins;
      clear_seen();
      run_cycles(vecs[v].hold);
      check({vecs[v].name, " value_out"}, 32'(value_out), 32'(vecs[v].exp_out));
      check({vecs[v].name, " rise bits"}, 32'(rise_or), 32'(vecs[v].exp_rise));
      check({vecs[v].name, " rise count"}, rise_tot, $countones(vecs[v].exp_rise));
      check({vecs[v].name, " fall bits"}, 32'(fall_or), 32'(vecs[v].exp_fall));
      check({vecs[v].name, " fall count"}, fall_tot, $countones(vecs[v].exp_fall));
    end

    // Exact latency of a single channel rise
    value_in = IDLE_PINS | 4'b0001;
    wait_event(lat, s_out, s_rise, s_fall);
    check("ch0 rise latency", lat, STABLE + 2);
    check("ch0 rise value_out", 32'(s_out), 32'(4'b0011));
    check("ch0 rise pulse bits", 32'({s_rise, s_fall}), 32'({4'b0001, 4'b0000}));
    @(posedge clk); #1;
    check("ch0 pulse width", 32'({rise_pulse, any_event}), 32'd0);
    @(negedge clk);
    value_in = IDLE_PINS;
    run_cycles(1010);

    // Simultaneous events on ch0 and ch3
    value_in = IDLE_PINS | 4'b1001;
    wait_event(lat, s_out, s_rise, s_fall);
    check("ch0+ch3 rise latency", lat, STABLE + 2);
    check("ch0+ch3 rise bits", 32'(s_rise), 32'(4'b1001));
    @(negedge clk);
    clear_seen();
    run_cycles(50);
    check("ch0+ch3 any_event one cycle", any_tot, 0);
    value_in = IDLE_PINS;
    wait_event(lat, s_out, s_rise, s_fall);
    check("ch0+ch3 fall latency", lat, STABLE + 2);
    check("ch0+ch3 fall bits", 32'({s_fall, s_rise}), 32'({4'b1001, 4'b0000}));
    @(negedge clk);
    run_cycles(20);

    // Reset in the middle of a count
    value_in = IDLE_PINS | 4'b0001;
    clear_seen();
    run_cycles(502);
    check("pre-reset no event", any_tot, 0);
    rstN = 1'b0;
    clear_seen();
    run_cycles(1);
    check("mid-count reset value_out", 32'(value_out), 32'(INIT));
    check("mid-count reset no pulse", any_tot + rise_tot + fall_tot, 0);
    rstN = 1'b1;
    wait_event(lat, s_out, s_rise, s_fall);
    check("recount after reset latency", lat, STABLE + 2);
    check("recount after reset rise bits", 32'(s_rise), 32'(4'b0001));
    @(negedge clk);
    value_in = IDLE_PINS;
    run_cycles(1010);

    // Randomized pins, checked cycle by cycle against the reference
    for (int seg = 0; seg < 36; seg++) begin
      rnd_pins = 4'($urandom());
      case ($urandom_range(0, 2))
        0:       rnd_hold = int'($urandom_range(1, 60));
        1:       rnd_hold = int'($urandom_range(995, 1005));
        default: rnd_hold = int'($urandom_range(1003, 1300));
      endcase
      value_in = rnd_pins;
      run_cycles(rnd_hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
